// File: rtl/clefia_f0_if.sv
// Request/result handshake bundle for clefia_f0; in_f1 exists only with CLEFIA_F1_SEL_EN.
interface clefia_f0_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_x;
   logic [31:0] in_rk;
`ifdef CLEFIA_F1_SEL_EN
   logic        in_f1;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_y;

`ifdef CLEFIA_F1_SEL_EN
   modport slave  (input  in_valid, in_x, in_rk, in_f1, out_ready,
                   output in_ready, out_valid, out_y);
   modport master (output in_valid, in_x, in_rk, in_f1, out_ready,
                   input  in_ready, out_valid, out_y);
`else
   modport slave  (input  in_valid, in_x, in_rk, out_ready,
                   output in_ready, out_valid, out_y);
   modport master (output in_valid, in_x, in_rk, out_ready,
                   input  in_ready, out_valid, out_y);
`endif
endinterface

// File: rtl/clefia_f0.sv
// CLEFIA F0 (S-box layer + M0 diffusion); F1 selectable per request when CLEFIA_F1_SEL_EN is defined.
// Latency 2 cycles, one result per cycle; in_ready falls only when both stages hold data and out_ready is low.
module clefia_f0 (
   input logic        clk,
   input logic        rst_n,
   clefia_f0_if.slave bus
);
   localparam logic [3:0] SS0 [16] = '{4'he, 4'h6, 4'hc, 4'ha, 4'h8, 4'h7, 4'h2, 4'hf,
                                       4'hb, 4'h1, 4'h4, 4'h0, 4'h5, 4'h9, 4'hd, 4'h3};
   localparam logic [3:0] SS1 [16] = '{4'h6, 4'h4, 4'h0, 4'hd, 4'h2, 4'hb, 4'ha, 4'h3,
                                       4'h9, 4'hc, 4'he, 4'hf, 4'h8, 4'h7, 4'h5, 4'h1};
   localparam logic [3:0] SS2 [16] = '{4'hb, 4'h8, 4'h5, 4'he, 4'ha, 4'h6, 4'h4, 4'hc,
                                       4'hf, 4'h7, 4'h2, 4'h3, 4'h1, 4'h0, 4'hd, 4'h9};
   localparam logic [3:0] SS3 [16] = '{4'ha, 4'h2, 4'h6, 4'hd, 4'h3, 4'h4, 4'h5, 4'he,
                                       4'h0, 4'h7, 4'h8, 4'h9, 4'hb, 4'hf, 4'hc, 4'h1};

   localparam logic [7:0] S1_TAB [256] = '{
      8'h6c,8'hda,8'hc3,8'he9,8'h4e,8'h9d,8'h0a,8'h3d,8'hb8,8'h36,8'hb4,8'h38,8'h13,8'h34,8'h0c,8'hd9,
      8'hbf,8'h74,8'h94,8'h8f,8'hb7,8'h9c,8'he5,8'hdc,8'h9e,8'h07,8'h49,8'h4f,8'h98,8'h2c,8'hb0,8'h93,
      8'h12,8'heb,8'hcd,8'hb3,8'h92,8'he7,8'h41,8'h60,8'he3,8'h21,8'h27,8'h3b,8'he6,8'h19,8'hd2,8'h0e,
      8'h91,8'h11,8'hc7,8'h3f,8'h2a,8'h8e,8'ha1,8'hbc,8'h2b,8'hc8,8'hc5,8'h0f,8'h5b,8'hf3,8'h87,8'h8b,
      8'hfb,8'hf5,8'hde,8'h20,8'hc6,8'ha7,8'h84,8'hce,8'hd8,8'h65,8'h51,8'hc9,8'ha4,8'hef,8'h43,8'h53,
      8'h25,8'h5d,8'h9b,8'h31,8'he8,8'h3e,8'h0d,8'hd7,8'h80,8'hff,8'h69,8'h8a,8'hba,8'h0b,8'h73,8'h5c,
      8'h6e,8'h54,8'h15,8'h62,8'hf6,8'h35,8'h30,8'h52,8'ha3,8'h16,8'hd3,8'h28,8'h32,8'hfa,8'haa,8'h5e,
      8'hcf,8'hea,8'hed,8'h78,8'h33,8'h58,8'h09,8'h7b,8'h63,8'hc0,8'hc1,8'h46,8'h1e,8'hdf,8'ha9,8'h99,
      8'h55,8'h04,8'hc4,8'h86,8'h39,8'h77,8'h82,8'hec,8'h40,8'h18,8'h90,8'h97,8'h59,8'hdd,8'h83,8'h1f,
      8'h9a,8'h37,8'h06,8'h24,8'h64,8'h7c,8'ha5,8'h56,8'h48,8'h08,8'h85,8'hd0,8'h61,8'h26,8'hca,8'h6f,
      8'h7e,8'h6a,8'hb6,8'h71,8'ha0,8'h70,8'h05,8'hd1,8'h45,8'h8c,8'h23,8'h1c,8'hf0,8'hee,8'h89,8'had,
      8'h7a,8'h4b,8'hc2,8'h2f,8'hdb,8'h5a,8'h4d,8'h76,8'h67,8'h17,8'h2d,8'hf4,8'hcb,8'hb1,8'h4a,8'ha8,
      8'hb5,8'h22,8'h47,8'h3a,8'hd5,8'h10,8'h4c,8'h72,8'hcc,8'h00,8'hf9,8'he0,8'hfd,8'he2,8'hfe,8'hae,
      8'hf8,8'h5f,8'hab,8'hf1,8'h1b,8'h42,8'h81,8'hd6,8'hbe,8'h44,8'h29,8'ha6,8'h57,8'hb9,8'haf,8'hf2,
      8'hd4,8'h75,8'h66,8'hbb,8'h68,8'h9f,8'h50,8'h02,8'h01,8'h3c,8'h7f,8'h8d,8'h1a,8'h88,8'hbd,8'hac,
      8'hf7,8'he4,8'h79,8'h96,8'ha2,8'hfc,8'h6d,8'hb2,8'h6b,8'h03,8'he1,8'h2e,8'h7d,8'h14,8'h95,8'h1d};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
   endfunction

   function automatic logic [3:0] xtime4(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
   endfunction

   // S0 is built from four 4-bit boxes around a GF(2^4) (z^4+z+1) 2x2 mix.
   function automatic logic [7:0] sbox0(input logic [7:0] x);
      logic [3:0] t0, t1, u0, u1;
      t0 = SS0[x[7:4]];
      t1 = SS1[x[3:0]];
      u0 = t0 ^ xtime4(t1);
      u1 = xtime4(t0) ^ t1;
      return {SS2[u0], SS3[u1]};
   endfunction

   function automatic logic [7:0] sbox1(input logic [7:0] x);
      return S1_TAB[x];
   endfunction

   logic        w_e1, w_e2;
   logic [31:0] w_t, w_sb, w_y;
   logic [7:0]  w_a [4];
   logic [7:0]  w_m2 [4];
   logic [7:0]  w_m4 [4];
   logic [7:0]  w_m6 [4];
   logic        r_s1_v, r_out_vld;
   logic [31:0] r_s1_t, r_out_y;
`ifdef CLEFIA_F1_SEL_EN
   logic        r_s1_f1;
   logic [7:0]  w_m8 [4];
   logic [7:0]  w_ma [4];
`endif

   assign w_e2         = !r_out_vld | bus.out_ready;
   assign w_e1         = !r_s1_v | w_e2;
   assign bus.in_ready = w_e1;
   assign bus.out_valid = r_out_vld;
   assign bus.out_y    = r_out_y;

   always_comb begin
      w_t = bus.in_x ^ bus.in_rk;
      w_sb = {sbox0(w_t[31:24]), sbox1(w_t[23:16]), sbox0(w_t[15:8]), sbox1(w_t[7:0])};
`ifdef CLEFIA_F1_SEL_EN
      if (bus.in_f1)
         w_sb = {sbox1(w_t[31:24]), sbox0(w_t[23:16]), sbox1(w_t[15:8]), sbox0(w_t[7:0])};
`endif
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_a[i]  = r_s1_t[31-8*i -: 8];
         w_m2[i] = xtime(w_a[i]);
         w_m4[i] = xtime(w_m2[i]);
         w_m6[i] = w_m4[i] ^ w_m2[i];
`ifdef CLEFIA_F1_SEL_EN
         w_m8[i] = xtime(w_m4[i]);
         w_ma[i] = w_m8[i] ^ w_m2[i];
`endif
      end
      w_y = {w_a[0]  ^ w_m2[1] ^ w_m4[2] ^ w_m6[3],
             w_m2[0] ^ w_a[1]  ^ w_m6[2] ^ w_m4[3],
             w_m4[0] ^ w_m6[1] ^ w_a[2]  ^ w_m2[3],
             w_m6[0] ^ w_m4[1] ^ w_m2[2] ^ w_a[3]};
`ifdef CLEFIA_F1_SEL_EN
      if (r_s1_f1)
         w_y = {w_a[0]  ^ w_m8[1] ^ w_m2[2] ^ w_ma[3],
                w_m8[0] ^ w_a[1]  ^ w_ma[2] ^ w_m2[3],
                w_m2[0] ^ w_ma[1] ^ w_a[2]  ^ w_m8[3],
                w_ma[0] ^ w_m2[1] ^ w_m8[2] ^ w_a[3]};
`endif
   end

   // Data registers only move on a real transfer so out_y holds steady under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_t    <= '0;
         r_out_vld <= 1'b0;
         r_out_y   <= '0;
`ifdef CLEFIA_F1_SEL_EN
         r_s1_f1   <= 1'b0;
`endif
      end else begin
         if (w_e1) begin
            r_s1_v <= bus.in_valid;
            if (bus.in_valid) begin
               r_s1_t  <= w_sb;
`ifdef CLEFIA_F1_SEL_EN
               r_s1_f1 <= bus.in_f1;
`endif
            end
         end
         if (w_e2) begin
            r_out_vld <= r_s1_v;
            if (r_s1_v)
               r_out_y <= w_y;
         end
      end
   end
endmodule

// File: tb/tb_clefia_f0.sv
// Scoreboard bench for clefia_f0: random traffic against a GF(2^8) matrix reference model.
module tb_clefia_f0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clefia_f0_if bus();
   clefia_f0 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int n_push = 0;
   int n_pop  = 0;
   int n_stall = 0;
   logic [31:0] exp_q [$];
   logic        hold_v = 1'b0;
   logic [31:0] hold_y = '0;

   logic [3:0] SS0 [16] = '{4'he,4'h6,4'hc,4'ha,4'h8,4'h7,4'h2,4'hf,4'hb,4'h1,4'h4,4'h0,4'h5,4'h9,4'hd,4'h3};
   logic [3:0] SS1 [16] = '{4'h6,4'h4,4'h0,4'hd,4'h2,4'hb,4'ha,4'h3,4'h9,4'hc,4'he,4'hf,4'h8,4'h7,4'h5,4'h1};
   logic [3:0] SS2 [16] = '{4'hb,4'h8,4'h5,4'he,4'ha,4'h6,4'h4,4'hc,4'hf,4'h7,4'h2,4'h3,4'h1,4'h0,4'hd,4'h9};
   logic [3:0] SS3 [16] = '{4'ha,4'h2,4'h6,4'hd,4'h3,4'h4,4'h5,4'he,4'h0,4'h7,4'h8,4'h9,4'hb,4'hf,4'hc,4'h1};
   logic [7:0] S1T [256] = '{
      8'h6c,8'hda,8'hc3,8'he9,8'h4e,8'h9d,8'h0a,8'h3d,8'hb8,8'h36,8'hb4,8'h38,8'h13,8'h34,8'h0c,8'hd9,
      8'hbf,8'h74,8'h94,8'h8f,8'hb7,8'h9c,8'he5,8'hdc,8'h9e,8'h07,8'h49,8'h4f,8'h98,8'h2c,8'hb0,8'h93,
      8'h12,8'heb,8'hcd,8'hb3,8'h92,8'he7,8'h41,8'h60,8'he3,8'h21,8'h27,8'h3b,8'he6,8'h19,8'hd2,8'h0e,
      8'h91,8'h11,8'hc7,8'h3f,8'h2a,8'h8e,8'ha1,8'hbc,8'h2b,8'hc8,8'hc5,8'h0f,8'h5b,8'hf3,8'h87,8'h8b,
      8'hfb,8'hf5,8'hde,8'h20,8'hc6,8'ha7,8'h84,8'hce,8'hd8,8'h65,8'h51,8'hc9,8'ha4,8'hef,8'h43,8'h53,
      8'h25,8'h5d,8'h9b,8'h31,8'he8,8'h3e,8'h0d,8'hd7,8'h80,8'hff,8'h69,8'h8a,8'hba,8'h0b,8'h73,8'h5c,
      8'h6e,8'h54,8'h15,8'h62,8'hf6,8'h35,8'h30,8'h52,8'ha3,8'h16,8'hd3,8'h28,8'h32,8'hfa,8'haa,8'h5e,
      8'hcf,8'hea,8'hed,8'h78,8'h33,8'h58,8'h09,8'h7b,8'h63,8'hc0,8'hc1,8'h46,8'h1e,8'hdf,8'ha9,8'h99,
      8'h55,8'h04,8'hc4,8'h86,8'h39,8'h77,8'h82,8'hec,8'h40,8'h18,8'h90,8'h97,8'h59,8'hdd,8'h83,8'h1f,
      8'h9a,8'h37,8'h06,8'h24,8'h64,8'h7c,8'ha5,8'h56,8'h48,8'h08,8'h85,8'hd0,8'h61,8'h26,8'hca,8'h6f,
      8'h7e,8'h6a,8'hb6,8'h71,8'ha0,8'h70,8'h05,8'hd1,8'h45,8'h8c,8'h23,8'h1c,8'hf0,8'hee,8'h89,8'had,
      8'h7a,8'h4b,8'hc2,8'h2f,8'hdb,8'h5a,8'h4d,8'h76,8'h67,8'h17,8'h2d,8'hf4,8'hcb,8'hb1,8'h4a,8'ha8,
      8'hb5,8'h22,8'h47,8'h3a,8'hd5,8'h10,8'h4c,8'h72,8'hcc,8'h00,8'hf9,8'he0,8'hfd,8'he2,8'hfe,8'hae,
      8'hf8,8'h5f,8'hab,8'hf1,8'h1b,8'h42,8'h81,8'hd6,8'hbe,8'h44,8'h29,8'ha6,8'h57,8'hb9,8'haf,8'hf2,
      8'hd4,8'h75,8'h66,8'hbb,8'h68,8'h9f,8'h50,8'h02,8'h01,8'h3c,8'h7f,8'h8d,8'h1a,8'h88,8'hbd,8'hac,
      8'hf7,8'he4,8'h79,8'h96,8'ha2,8'hfc,8'h6d,8'hb2,8'h6b,8'h03,8'he1,8'h2e,8'h7d,8'h14,8'h95,8'h1d};

   // Schoolbook carry-less product, then polynomial long-division remainder.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011d << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [3:0] gmul16(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({4'h0, a} << i);
      for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
      return p[3:0];
   endfunction

   function automatic logic [7:0] s0_ref(input logic [7:0] x);
      logic [3:0] t0, t1;
      t0 = SS0[x[7:4]];
      t1 = SS1[x[3:0]];
      return {SS2[t0 ^ gmul16(4'h2, t1)], SS3[gmul16(4'h2, t0) ^ t1]};
   endfunction

   // Both diffusion matrices are Hadamard: entry (i,j) = c[i^j].
   function automatic logic [31:0] f_ref(input logic [31:0] x, input logic [31:0] rk, input logic f1);
      logic [31:0] t, y;
      logic [7:0]  s [4];
      logic [7:0]  c [4];
      logic [7:0]  acc;
      t = x ^ rk;
      if (f1) begin c[0] = 8'h01; c[1] = 8'h08; c[2] = 8'h02; c[3] = 8'h0a; end
      else    begin c[0] = 8'h01; c[1] = 8'h02; c[2] = 8'h04; c[3] = 8'h06; end
      for (int i = 0; i < 4; i++)
         s[i] = (((i % 2) == 0) ^ f1) ? s0_ref(t[31-8*i -: 8]) : S1T[t[31-8*i -: 8]];
      y = '0;
      for (int i = 0; i < 4; i++) begin
         acc = '0;
         for (int j = 0; j < 4; j++) acc = acc ^ gmul(c[i ^ j], s[j]);
         y[31-8*i -: 8] = acc;
      end
      return y;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] rk,
                        input logic f1, input logic ordy);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_x      = x;
      bus.in_rk     = rk;
      bus.out_ready = ordy;
`ifdef CLEFIA_F1_SEL_EN
      bus.in_f1     = f1;
`endif
      #1;
      if (v && bus.in_ready) begin
         exp_q.push_back(f_ref(x, rk, f1));
         n_push++;
      end else if (v) n_stall++;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         n++;
      end
      chk(name, exp_q.size(), 0);
      chk({name, "_count"}, n_pop, n_push);
   endtask

   // Monitor: pops on every output transfer, and checks out_y is frozen while stalled.
   always @(negedge clk) begin
      #2;
      if (!rst_n) hold_v = 1'b0;
      else begin
         if (hold_v) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_y, hold_y);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %08h expected no output", bus.out_y);
            end else begin
               n_pop++;
               chk("result", bus.out_y, exp_q.pop_front());
            end
         end
         hold_v = bus.out_valid && !bus.out_ready;
         hold_y = bus.out_y;
      end
   end

   initial begin
      int p;
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_rk     = '0;
      bus.out_ready = 1'b1;
`ifdef CLEFIA_F1_SEL_EN
      bus.in_f1     = 1'b0;
`endif
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_y", bus.out_y, 0);
      chk("rst_s1_t", dut.r_s1_t, 0);
      repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b1);
      rst_n = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      chk("idle_in_ready", bus.in_ready, 1);

      // Zero vector and exact latency
      drive(1'b1, '0, '0, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      chk("zero_sbox", dut.r_s1_t, 32'h576c576c);
      chk("zero_lat1_valid", bus.out_valid, 0);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      chk("zero_lat2_valid", bus.out_valid, 1);
      chk("zero_y", bus.out_y, 32'hbb80bb80);
      drain("zero_drain");

      // Back-to-back burst
      n_stall = 0;
      for (int i = 0; i < 1000; i++) drive(1'b1, $urandom, $urandom, 1'b0, 1'b1);
      chk("burst_stalls", n_stall, 0);
      drain("burst_drain");

      // Full pipe, then 5 stalled cycles
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
         chk("stall_in_ready", bus.in_ready, 0);
      end
      p = n_pop;
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      chk("release_in_ready", bus.in_ready, 1);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      #3;
      chk("release_two_words", n_pop - p, 2);
      drain("stall_drain");

      // Random valid/ready toggling
      for (int i = 0; i < 600; i++)
         drive(1'(($urandom % 2)), $urandom, $urandom, 1'b0, 1'(($urandom % 2)));
      drain("random_drain");

      // Asynchronous reset with two words in flight
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("pre_reset_valid", bus.out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_out_y", bus.out_y, 0);
      chk("mid_rst_s1_v", dut.r_s1_v, 0);
      exp_q.delete();
      n_push = 0;
      n_pop  = 0;
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         chk("post_rst_no_output", bus.out_valid, 0);
      end

`ifdef CLEFIA_F1_SEL_EN
      for (int i = 0; i < 8; i++) drive(1'b1, '0, '0, 1'(i % 2), 1'b1);
      drain("f0_f1_drain");
`endif
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
